// File: rtl/seg_scan_mux_if.sv
// Connection bundle between core logic and the 7-segment scan driver.
// Digit data and display controls flow in; pin-level segment/anode drive
// and the frame strobe flow out.
// There is no valid/ready handshake on this bundle. Every input is a level
// that the driver samples only at a frame start. Every output is a registered
// pin level that is valid on every cycle.
interface seg_scan_mux_if #(
    parameter int DIGITS = 8,
    parameter int GROUPS = 2
);
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   dp_mask;
    logic [DIGITS-1:0]   blank_mask;
    logic [DIGITS-1:0]   blink_mask;
    logic                lz_en;
    logic [3:0]          bright;
    logic [8*GROUPS-1:0] seg;
    logic [DIGITS-1:0]   an;
    logic                frame_pulse;

    modport master (
        output digits, dp_mask, blank_mask, blink_mask, lz_en, bright,
        input  seg, an, frame_pulse
    );

    modport slave (
        input  digits, dp_mask, blank_mask, blink_mask, lz_en, bright,
        output seg, an, frame_pulse
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scan driver. GROUPS segment buses each scan
// P = DIGITS/GROUPS digits in parallel. Each slot starts with an anti-ghosting
// dead time. Inside the rest of the slot the anode is gated by a 16-step PWM
// for brightness. Inputs are shadowed once per frame, so a frame never shows
// a mix of old and new values.
module seg_scan_mux #(
    parameter int DIGITS       = 8,
    parameter int GROUPS       = 2,
    parameter int SCAN_DIV     = 250000,
    parameter int BLANK_CYC    = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter bit SEG_ACT_LOW  = 1'b0,
    parameter bit AN_ACT_LOW   = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_mux_if.slave bus
);
    localparam int P  = DIGITS / GROUPS;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SW-1:0]       slot_cnt;
    logic [PW-1:0]       pos;
    logic [3:0]          pwm_cnt;
    logic [FW-1:0]       frame_cnt;
    logic                blink_ph;

    logic [4*DIGITS-1:0] digits_sh;
    logic [DIGITS-1:0]   dp_sh;
    logic [DIGITS-1:0]   blank_sh;
    logic [DIGITS-1:0]   blink_sh;
    logic                lz_en_sh;
    logic [3:0]          bright_sh;

    logic [8*GROUPS-1:0] seg_nx;
    logic [8*GROUPS-1:0] seg_q;
    logic [DIGITS-1:0]   an_nx;
    logic [DIGITS-1:0]   an_q;
    logic                frame_pulse_q;

    logic frame_start;
    logic slot_end;
    logic pos_end;
    logic scan_open;

    assign frame_start = (slot_cnt == '0) && (pos == '0);
    assign slot_end    = (slot_cnt == SW'(SCAN_DIV - 1));
    assign pos_end     = (pos == PW'(P - 1));
    // The dead time has passed and the PWM phase is inside the on-window.
    assign scan_open   = (slot_cnt >= SW'(BLANK_CYC)) && (pwm_cnt <= bright_sh);

    // Map a hex nibble to active-high segments, bit order g..a.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'b0111111;
            4'h1: decode = 7'b0000110;
            4'h2: decode = 7'b1011011;
            4'h3: decode = 7'b1001111;
            4'h4: decode = 7'b1100110;
            4'h5: decode = 7'b1101101;
            4'h6: decode = 7'b1111101;
            4'h7: decode = 7'b0000111;
            4'h8: decode = 7'b1111111;
            4'h9: decode = 7'b1101111;
            4'hA: decode = 7'b1110111;
            4'hB: decode = 7'b1111100;
            4'hC: decode = 7'b0111001;
            4'hD: decode = 7'b1011110;
            4'hE: decode = 7'b1111001;
            default: decode = 7'b1110001;
        endcase
    endfunction

    // Scan timebase: slot counter, digit position, PWM phase and blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            pos       <= '0;
            pwm_cnt   <= '0;
            frame_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (slot_end) begin
                slot_cnt <= '0;
                pos      <= pos_end ? '0 : pos + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
            if (frame_start) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Capture every display input once per frame so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_sh <= '0;
            dp_sh     <= '0;
            blank_sh  <= '0;
            blink_sh  <= '0;
            lz_en_sh  <= 1'b0;
            bright_sh <= '0;
        end else if (frame_start) begin
            digits_sh <= bus.digits;
            dp_sh     <= bus.dp_mask;
            blank_sh  <= bus.blank_mask;
            blink_sh  <= bus.blink_mask;
            lz_en_sh  <= bus.lz_en;
            bright_sh <= bus.bright;
        end
    end

    // Next pin state: select each group's current digit, gate it, then decode it.
    always_comb begin
        logic              zero_run;
        logic [DIGITS-1:0] lz_hide;
        int                idx;
        logic [3:0]        nib;
        seg_nx   = '0;
        an_nx    = '0;
        lz_hide  = '0;
        zero_run = 1'b0;
        idx      = 0;
        nib      = '0;
        // Walk each group from its top position down. A digit is hidden while
        // it and everything above it are still zero. Position 0 always shows.
        for (int g = 0; g < GROUPS; g++) begin
            zero_run = 1'b1;
            for (int p = P - 1; p >= 0; p--) begin
                zero_run         = zero_run & (digits_sh[4*(g*P+p) +: 4] == 4'h0);
                lz_hide[g*P + p] = lz_en_sh && zero_run && (p != 0);
            end
        end
        for (int g = 0; g < GROUPS; g++) begin
            idx = g*P + int'(pos);
            nib = digits_sh[4*idx +: 4];
            if (scan_open && !blank_sh[idx] && !(blink_sh[idx] && blink_ph)) begin
                an_nx[idx]         = 1'b1;
                seg_nx[8*g +: 7]   = lz_hide[idx] ? 7'd0 : decode(nib);
                seg_nx[8*g + 7]    = dp_sh[idx];
            end
        end
    end

    // Pin registers. Polarity is applied here, so pins are glitch-free and
    // sit at their inactive level while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q          <= {DIGITS{AN_ACT_LOW}};
            seg_q         <= {(8*GROUPS){SEG_ACT_LOW}};
            frame_pulse_q <= 1'b0;
        end else begin
            an_q          <= an_nx ^ {DIGITS{AN_ACT_LOW}};
            seg_q         <= seg_nx ^ {(8*GROUPS){SEG_ACT_LOW}};
            frame_pulse_q <= frame_start;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.frame_pulse = frame_pulse_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux. A reference model predicts the pins after every
// clock edge. It works from the edge count since reset release and from the
// inputs that were present at each frame start.
module tb_seg_scan_mux;
    localparam int D     = 8;
    localparam int G     = 2;
    localparam int P     = D / G;
    localparam int SD    = 40;
    localparam int BLANK = 4;
    localparam int BF    = 2;
    localparam int FL    = P * SD;
    localparam int W     = 1 + D + 8*G;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Clock and reset
    always #5 clk = ~clk;

    seg_scan_mux_if #(.DIGITS(D), .GROUPS(G)) bus ();

    seg_scan_mux #(
        .DIGITS(D), .GROUPS(G), .SCAN_DIV(SD), .BLANK_CYC(BLANK),
        .BLINK_FRAMES(BF), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int n      = -1;
    logic [W-1:0] exp_q[$];
    logic [6:0]   seg_tab[16];

    // Inputs as they stood at the most recent frame start
    logic [4*D-1:0] m_digits;
    logic [D-1:0]   m_dp, m_blank, m_blink;
    logic           m_lz;
    logic [3:0]     m_bright;

    // Expected {frame_pulse, an, seg} after the clock edge with index k
    function automatic logic [W-1:0] model(input int k);
        int slot, p0, pwm, frame, ph, idx;
        bit on, zrun;
        logic [6:0]   s7;
        logic [D-1:0] e_an;
        logic [8*G-1:0] e_seg;
        slot  = k % SD;
        p0    = (k / SD) % P;
        pwm   = k % 16;
        frame = k / FL;
        ph    = ((frame + 1) / BF) % 2;
        e_an  = '0;
        e_seg = '0;
        for (int g = 0; g < G; g++) begin
            idx = g*P + p0;
            on  = (slot >= BLANK) && (pwm <= int'(m_bright)) && !m_blank[idx] &&
                  !(m_blink[idx] && ph == 1);
            if (on) begin
                zrun = 1'b1;
                for (int p = p0; p < P; p++)
                    if (m_digits[4*(g*P+p) +: 4] != 4'h0) zrun = 1'b0;
                s7 = (m_lz && p0 != 0 && zrun) ? 7'd0 : seg_tab[m_digits[4*idx +: 4]];
                e_an[idx]        = 1'b1;
                e_seg[8*g +: 8]  = {m_dp[idx], s7};
            end
        end
        return {(k % FL == 0), e_an, e_seg};
    endfunction

    // Driver: apply a complete set of display inputs
    task automatic drive(input logic [4*D-1:0] d, input logic [D-1:0] dp, input logic [D-1:0] bl,
                         input logic [D-1:0] bk, input logic lz, input logic [3:0] br);
        bus.digits     = d;
        bus.dp_mask    = dp;
        bus.blank_mask = bl;
        bus.blink_mask = bk;
        bus.lz_en      = lz;
        bus.bright     = br;
    endtask

    task automatic drive_random();
        drive({$urandom(), $urandom()} >> (64 - 4*D), D'($urandom()), D'($urandom_range(0, 3)),
              D'($urandom_range(0, 3)), 1'($urandom()), 4'($urandom_range(0, 15)));
    endtask

    // Advance one clock edge, update the model and queue its prediction.
    // Returns at the following falling edge, where the pins are sampled.
    task automatic step();
        @(posedge clk);
        n++;
        if (n % FL == 0) begin
            m_digits = bus.digits;
            m_dp     = bus.dp_mask;
            m_blank  = bus.blank_mask;
            m_blink  = bus.blink_mask;
            m_lz     = bus.lz_en;
            m_bright = bus.bright;
        end
        exp_q.push_back(model(n));
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [W-1:0] got;
        rst_n = 1'b0;
        drive(32'h7654_3210, '0, '0, '0, 1'b0, 4'd15);
        repeat (3) @(negedge clk);
        got = {bus.frame_pulse, bus.an, bus.seg};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", got);
        end
        rst_n = 1'b1;
        n = -1;
        exp_q.delete();
    endtask

    task automatic test_basic_scan();
        logic [W-1:0] got, exp;
        for (int c = 0; c < 2*FL; c++) begin
            step();
            got = {bus.frame_pulse, bus.an, bus.seg};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_scan n=%0d got=%h exp=%h", n, got, exp);
            end
        end
    endtask

    task automatic test_pwm();
        logic [W-1:0] got, exp;
        drive({$urandom()}, D'($urandom()), '0, '0, 1'b0, 4'd3);
        for (int c = 0; c < 2*FL + SD; c++) begin
            step();
            got = {bus.frame_pulse, bus.an, bus.seg};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pwm n=%0d got=%h exp=%h", n, got, exp);
            end
        end
    endtask

    task automatic test_lz();
        logic [W-1:0] got, exp;
        drive(32'h0007_0000, D'($urandom()), '0, '0, 1'b1, 4'd15);
        for (int c = 0; c < 2*FL + SD; c++) begin
            step();
            got = {bus.frame_pulse, bus.an, bus.seg};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL lz n=%0d got=%h exp=%h", n, got, exp);
            end
        end
    endtask

    task automatic test_blink_blank();
        logic [W-1:0] got, exp;
        drive({$urandom()}, D'($urandom()), 8'h80, 8'h01, 1'b0, 4'd15);
        for (int c = 0; c < 6*FL; c++) begin
            step();
            got = {bus.frame_pulse, bus.an, bus.seg};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL blink_blank n=%0d got=%h exp=%h", n, got, exp);
            end
        end
    endtask

    // Inputs change at random points, mostly mid-frame
    task automatic test_random();
        logic [W-1:0] got, exp;
        for (int c = 0; c < 6*FL; c++) begin
            step();
            got = {bus.frame_pulse, bus.an, bus.seg};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random n=%0d got=%h exp=%h", n, got, exp);
            end
            if ($urandom_range(0, 49) == 0) drive_random();
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] got, exp;
        int budget;
        bit found;
        drive({$urandom()}, '0, '0, '0, 1'b0, 4'd15);
        found  = 1'b0;
        budget = 3*FL;
        // Run until the counters hold slot 20 at position 2
        while (!found && budget > 0) begin
            step();
            budget--;
            got = {bus.frame_pulse, bus.an, bus.seg};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pre_reset n=%0d got=%h exp=%h", n, got, exp);
            end
            found = (((n + 1) % SD) == 20) && ((((n + 1) / SD) % P) == 2);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_point not reached within budget");
        end
        #2 rst_n = 1'b0;
        #1;
        got = {bus.frame_pulse, bus.an, bus.seg};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", got);
        end
        drive({$urandom()}, D'($urandom()), '0, '0, 1'b0, 4'd15);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = -1;
        exp_q.delete();
        for (int c = 0; c < FL + SD; c++) begin
            step();
            got = {bus.frame_pulse, bus.an, bus.seg};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL post_reset n=%0d got=%h exp=%h", n, got, exp);
            end
        end
    endtask

    initial begin
        seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        m_digits = '0;
        m_dp     = '0;
        m_blank  = '0;
        m_blink  = '0;
        m_lz     = 1'b0;
        m_bright = '0;
        test_reset();
        test_basic_scan();
        test_pwm();
        test_lz();
        test_blink_blank();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
